cpu_control_fsm: RTL and testbench

// - Multi-cycle control sequencer for the 16-bit CPU; drives fetch, decode, execute, memory and writeback.
// - Consumes opcode and condition-pass from the instruction decoder.
// - Generates register-file, flag, PC and instruction/data memory strobes with req/ack handshakes.
// - Sits between the decoder, ALU, register file and the two memory ports.

---
 rtl/cpu_control_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/memory/writeback sequencer
// for the 16-bit CPU. Strobes are decoded from the registered state, qualified
// by the handshake inputs where a same-cycle response is needed (ir_load, the
// store-completion pc_inc, the skipped-instruction pc_inc).
// Optional feature macro: CTRL_PERF_CNT_EN adds retired/skipped counters.
module cpu_control_fsm #(
    parameter logic [3:0]  OP_LOAD  = 4'b1101,
    parameter logic [3:0]  OP_STORE = 4'b1110,
    parameter logic [3:0]  OP_HALT  = 4'b1111,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       cc_success,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_load,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       flags_we,
    output logic       rf_we,
    output logic       rf_wsel,
    output logic       pc_inc,
    output logic       halted,
    output logic       err,
    output logic [2:0] state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0] retired_cnt,
    output logic [15:0] skipped_cnt
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               is_load_c;
    logic               is_store_c;

    assign is_load_c  = (opcode == OP_LOAD);
    assign is_store_c = (opcode == OP_STORE);

    // State, wait counter and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, wait-counter and error-flag logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                // An ack on the final wait cycle still wins over the timeout
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (!cc_success) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_load_c || is_store_c) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_store_c) begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_HALT: begin
                if (!run) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // Strobe decode from the registered state plus same-cycle handshakes
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        flags_we = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        pc_inc   = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_DECODE: begin
                pc_inc = ~cc_success;
            end
            S_EXEC: begin
                flags_we = 1'b1;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store_c;
                pc_inc   = is_store_c & dmem_ack;
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wsel = is_load_c;
                pc_inc  = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign err   = err_q;
    assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_q;
    logic [15:0] skipped_q;
    logic        retire_c;
    logic        skip_c;

    assign retire_c = (state_q == S_WB) ||
                      ((state_q == S_MEM) && dmem_ack && is_store_c);
    assign skip_c   = (state_q == S_DECODE) && !cc_success;

    // Retired/skipped instruction counters; wrap naturally, idle in HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            skipped_q <= '0;
        end else begin
            if (retire_c) begin
                retired_q <= retired_q + 16'd1;
            end
            if (skip_c) begin
                skipped_q <= skipped_q + 16'd1;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign skipped_cnt = skipped_q;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed stimulus with a per-cycle expected-output
// scoreboard; a negedge monitor pops and compares each queued expectation.
module tb_cpu_control_fsm;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] opcode;
    logic       cc_success;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       flags_we;
    logic       rf_we;
    logic       rf_wsel;
    logic       pc_inc;
    logic       halted;
    logic       err;
    logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt;
    logic [15:0] skipped_cnt;
`endif

    cpu_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .cc_success (cc_success),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .ir_load    (ir_load),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .flags_we   (flags_we),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .pc_inc     (pc_inc),
        .halted     (halted),
        .err        (err),
        .state      (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt),
        .skipped_cnt(skipped_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe bit positions in the compared vector
    localparam logic [9:0] ERR = 10'h001;
    localparam logic [9:0] HLT = 10'h002;
    localparam logic [9:0] PCI = 10'h004;
    localparam logic [9:0] WSL = 10'h008;
    localparam logic [9:0] RFW = 10'h010;
    localparam logic [9:0] FLW = 10'h020;
    localparam logic [9:0] DWE = 10'h040;
    localparam logic [9:0] DRQ = 10'h080;
    localparam logic [9:0] IRL = 10'h100;
    localparam logic [9:0] IRQ = 10'h200;
    localparam logic [9:0] NON = 10'h000;

    localparam logic [3:0] OPA = 4'b0010;
    localparam logic [3:0] OPL = 4'b1101;
    localparam logic [3:0] OPS = 4'b1110;
    localparam logic [3:0] OPH = 4'b1111;

    typedef struct {
        string       name;
        logic [12:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [12:0] e(input logic [2:0] st, input logic [9:0] m);
        return {st, m};
    endfunction

    // Apply one cycle of inputs and queue the outputs expected during it
    task automatic cyc(input string nm, input logic r, input logic [3:0] op,
                       input logic cc, input logic ia, input logic da,
                       input logic [12:0] ev);
        exp_t x;
        run        = r;
        opcode     = op;
        cc_success = cc;
        imem_ack   = ia;
        dmem_ack   = da;
        x.name     = nm;
        x.v        = ev;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare queued expectation against the DUT mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [12:0] got;
            x   = exp_q.pop_front();
            got = {state, imem_req, ir_load, dmem_req, dmem_we, flags_we,
                   rf_we, rf_wsel, pc_inc, halted, err};
            checks++;
            if (got !== x.v) begin
                errors++;
                $display("FAIL %s got st=%0d strobes=%b exp st=%0d strobes=%b",
                         x.name, got[12:10], got[9:0], x.v[12:10], x.v[9:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = '0; cc_success = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset state, then an ALU instruction with same-cycle fetch ack
        cyc("reset_idle",  0, OPA, 1, 0, 0, e(0, NON));
        cyc("idle_start",  1, OPA, 1, 1, 0, e(0, NON));
        cyc("alu_fetch",   1, OPA, 1, 1, 0, e(1, IRQ | IRL));
        cyc("alu_decode",  1, OPA, 1, 1, 1, e(2, NON));
        cyc("alu_exec",    1, OPA, 1, 1, 1, e(3, FLW));
        cyc("alu_wb",      1, OPA, 1, 0, 0, e(5, RFW | PCI));

        // Failed condition: skip straight back to FETCH
        cyc("skip_fetch",  1, OPA, 0, 1, 0, e(1, IRQ | IRL));
        cyc("skip_decode", 1, OPA, 0, 0, 1, e(2, PCI));

        // Load with three dmem wait cycles
        cyc("ld_fetch",    1, OPL, 1, 1, 0, e(1, IRQ | IRL));
        cyc("ld_decode",   1, OPL, 1, 0, 0, e(2, NON));
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", 1, OPL, 1, 0, 0, e(4, DRQ));
        cyc("ld_mem_ack",  1, OPL, 1, 0, 1, e(4, DRQ));
        cyc("ld_wb",       1, OPL, 1, 0, 0, e(5, RFW | WSL | PCI));

        // Store with immediate ack
        cyc("st_fetch",    1, OPS, 1, 1, 0, e(1, IRQ | IRL));
        cyc("st_decode",   1, OPS, 1, 0, 0, e(2, NON));
        cyc("st_mem_ack",  1, OPS, 1, 0, 1, e(4, DRQ | DWE | PCI));

        // HALT opcode; leave on run=0
        cyc("h_fetch",     1, OPH, 1, 1, 0, e(1, IRQ | IRL));
        cyc("h_decode",    1, OPH, 1, 0, 0, e(2, NON));
        cyc("h_hold",      1, OPH, 1, 0, 0, e(6, HLT));
        cyc("h_release",   0, OPH, 1, 0, 0, e(6, HLT));
        cyc("h_idle",      0, OPH, 1, 0, 0, e(0, NON));

        // Fetch timeout after 15 cycles of no ack
        cyc("to_start",    1, OPA, 1, 0, 0, e(0, NON));
        for (int i = 0; i < 15; i++)
            cyc("to_fetch_wait", 1, OPA, 1, 0, 0, e(1, IRQ));
        cyc("to_halt",     1, OPA, 1, 1, 1, e(6, HLT | ERR));
        cyc("to_release",  0, OPA, 1, 0, 0, e(6, HLT | ERR));
        cyc("to_idle",     0, OPA, 1, 0, 0, e(0, NON));

        // Ack on the final wait cycle beats the timeout
        cyc("edge_start",  1, OPA, 0, 0, 0, e(0, NON));
        for (int i = 0; i < 14; i++)
            cyc("edge_wait", 1, OPA, 0, 0, 0, e(1, IRQ));
        cyc("edge_ack",    1, OPA, 0, 1, 0, e(1, IRQ | IRL));
        cyc("edge_skip",   1, OPA, 0, 0, 0, e(2, PCI));

`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (retired_cnt !== 16'd3) begin
            errors++;
            $display("FAIL retired_cnt got=%0d exp=3", retired_cnt);
        end
        checks++;
        if (skipped_cnt !== 16'd2) begin
            errors++;
            $display("FAIL skipped_cnt got=%0d exp=2", skipped_cnt);
        end
`endif

        // Async reset while a load holds dmem_req
        cyc("rs_fetch",    1, OPL, 1, 1, 0, e(1, IRQ | IRL));
        cyc("rs_decode",   1, OPL, 1, 0, 0, e(2, NON));
        cyc("rs_mem",      1, OPL, 1, 0, 0, e(4, DRQ));
        rst_n = 1'b0;
        cyc("rs_async",    1, OPL, 1, 1, 1, e(0, NON));
        rst_n = 1'b1;
        cyc("rs_after",    0, OPL, 1, 0, 0, e(0, NON));

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
